cache_bank_core_rsp_queue: RTL and testbench

Per-bank core-response queue between the bank pipeline's response output and the core response merge stage. It is one instance per bank. It buffers response entries {pmask, data, tid, tag} in a first-word-fall-through ring buffer and presents them to the merge stage with a valid/ready handshake. It also drives an almost-full flag that the bank pipeline uses to stall new fills/hits before the queue can overflow.

---
 rtl/cache_bank_core_rsp_queue.sv | 125 ++++++++++++
 tb/tb_cache_bank_core_rsp_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_bank_core_rsp_queue.sv
// Per-bank core-response queue: first-word-fall-through ring buffer between the bank
// pipeline's response output and the core response merge stage.
module cache_bank_core_rsp_queue #(
  parameter int unsigned CACHE_ID       = 0,
  parameter int unsigned NUM_REQS       = 4,
  parameter int unsigned NUM_PORTS      = 1,
  parameter int unsigned WORD_SIZE      = 4,
  parameter int unsigned CORE_TAG_WIDTH = 8,
  parameter int unsigned CRSQ_SIZE      = 4,
  parameter int unsigned CRSQ_ALM_FULL  = 2,
  localparam int unsigned REQS_BITS     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int unsigned WORD_WIDTH    = 8 * WORD_SIZE,
  localparam int unsigned PTR_W         = $clog2(CRSQ_SIZE),
  localparam int unsigned CNT_W         = PTR_W + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enq_valid,
  input  logic [NUM_PORTS-1:0]            enq_pmask,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] enq_data,
  input  logic [NUM_PORTS*REQS_BITS-1:0]  enq_tid,
  input  logic [CORE_TAG_WIDTH-1:0]       enq_tag,
  output logic                            enq_ready,
  output logic                            alm_full,
  output logic                            rsp_valid,
  output logic [NUM_PORTS-1:0]            rsp_pmask,
  output logic [NUM_PORTS*WORD_WIDTH-1:0] rsp_data,
  output logic [NUM_PORTS*REQS_BITS-1:0]  rsp_tid,
  output logic [CORE_TAG_WIDTH-1:0]       rsp_tag,
  input  logic                            rsp_ready,
  output logic [CNT_W-1:0]                size
);

  localparam int unsigned ENTRY_W = NUM_PORTS + NUM_PORTS * WORD_WIDTH
                                  + NUM_PORTS * REQS_BITS + CORE_TAG_WIDTH;
  localparam logic [CNT_W-1:0] FullCount = CNT_W'(CRSQ_SIZE);
  localparam logic [CNT_W-1:0] AlmCount  = CNT_W'(CRSQ_ALM_FULL);

  typedef logic [ENTRY_W-1:0] entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alm_full_q, alm_full_d;
  entry_t           mem_q [CRSQ_SIZE];
  entry_t           mem_d [CRSQ_SIZE];

  entry_t enq_entry;
  logic   push;
  logic   pop;

  assign enq_entry = {enq_pmask, enq_data, enq_tid, enq_tag};

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a full queue.
  assign enq_ready = (count_q != FullCount) && reset;
  assign rsp_valid = (count_q != '0);
  assign push      = enq_valid && enq_ready;
  assign pop       = rsp_valid && rsp_ready;

  assign {rsp_pmask, rsp_data, rsp_tid, rsp_tag} = mem_q[rd_ptr_q];
  assign size     = count_q;
  assign alm_full = alm_full_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    alm_full_d = (count_d >= AlmCount);
  end

  always_comb begin
    for (int i = 0; i < CRSQ_SIZE; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = enq_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alm_full_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      alm_full_q <= alm_full_d;
    end
  end

  // Entry storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CRSQ_SIZE; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  a_push_pmask: assert property (@(posedge clk) disable iff (!reset)
    push |-> (enq_pmask != '0))
    else $error("crsq%0d: push with empty pmask", CACHE_ID);

  a_enq_hold: assert property (@(posedge clk) disable iff (!reset)
    (enq_valid && !enq_ready) |=> (enq_valid && $stable(enq_pmask) && $stable(enq_data)
                                   && $stable(enq_tid) && $stable(enq_tag)))
    else $error("crsq%0d: stalled enqueue dropped or changed", CACHE_ID);

  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    count_q <= FullCount)
    else $error("crsq%0d: occupancy overflow", CACHE_ID);

endmodule

// File: tb/tb_cache_bank_core_rsp_queue.sv
// Directed self-checking bench for cache_bank_core_rsp_queue (default parameters).
module tb_cache_bank_core_rsp_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic [0:0]  enq_pmask;
  logic [31:0] enq_data;
  logic [1:0]  enq_tid;
  logic [7:0]  enq_tag;
  logic        enq_ready;
  logic        alm_full;
  logic        rsp_valid;
  logic [0:0]  rsp_pmask;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tid;
  logic [7:0]  rsp_tag;
  logic        rsp_ready;
  logic [2:0]  size;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_bank_core_rsp_queue dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_pmask (enq_pmask),
    .enq_data  (enq_data),
    .enq_tid   (enq_tid),
    .enq_tag   (enq_tag),
    .enq_ready (enq_ready),
    .alm_full  (alm_full),
    .rsp_valid (rsp_valid),
    .rsp_pmask (rsp_pmask),
    .rsp_data  (rsp_data),
    .rsp_tid   (rsp_tid),
    .rsp_tag   (rsp_tag),
    .rsp_ready (rsp_ready),
    .size      (size)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [31:0] d, input logic [1:0] t,
                           input logic [7:0] g);
    enq_valid = v;
    enq_pmask = 1'b1;
    enq_data  = d;
    enq_tid   = t;
    enq_tag   = g;
  endtask

  task automatic test_reset();
    reset = 1'b0; rsp_ready = 1'b0;
    drive_enq(1'b0, 32'h0, 2'd0, 8'h0);
    tick(); tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
    vectors++; if (size !== 3'd0) begin miscompares++; $display("FAIL reset_size: got %0d expected 0", size); end
    vectors++; if (alm_full !== 1'b0) begin miscompares++; $display("FAIL reset_alm_full: got %0h expected 0", alm_full); end
    vectors++; if (enq_ready !== 1'b0) begin miscompares++; $display("FAIL reset_enq_ready_low: got %0h expected 0", enq_ready); end
    reset = 1'b1;
    #1;
    vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_enq_ready_high: got %0h expected 1", enq_ready); end
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    drive_enq(1'b1, 32'hDEADBEEF, 2'd2, 8'h5A);
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass: got %0h expected 0", rsp_valid); end
    tick();
    enq_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0h expected 1", rsp_valid); end
    vectors++; if (rsp_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data: got %0h expected deadbeef", rsp_data); end
    vectors++; if (rsp_tid !== 2'd2) begin miscompares++; $display("FAIL single_tid: got %0d expected 2", rsp_tid); end
    vectors++; if (rsp_tag !== 8'h5A) begin miscompares++; $display("FAIL single_tag: got %0h expected 5a", rsp_tag); end
    vectors++; if (rsp_pmask !== 1'b1) begin miscompares++; $display("FAIL single_pmask: got %0h expected 1", rsp_pmask); end
    vectors++; if (size !== 3'd1) begin miscompares++; $display("FAIL single_size1: got %0d expected 1", size); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained: got %0h expected 0", rsp_valid); end
    vectors++; if (size !== 3'd0) begin miscompares++; $display("FAIL single_size0: got %0d expected 0", size); end
  endtask

  task automatic test_fill();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, 32'h10 + 32'(i), 2'(i), 8'(i));
      tick();
      vectors++; if (size !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_size[%0d]: got %0d expected %0d", i, size, i + 1); end
      vectors++; if (alm_full !== (i >= 1)) begin miscompares++; $display("FAIL fill_alm_full[%0d]: got %0h expected %0h", i, alm_full, (i >= 1)); end
    end
    vectors++; if (enq_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready: got %0h expected 0", enq_ready); end
    drive_enq(1'b1, 32'h14, 2'd0, 8'h04);
    tick();
    vectors++; if (size !== 3'd4) begin miscompares++; $display("FAIL fill_held_size: got %0d expected 4", size); end
    vectors++; if (rsp_data !== 32'h10) begin miscompares++; $display("FAIL fill_head: got %0h expected 10", rsp_data); end
  endtask

  task automatic test_full_pop();
    rsp_ready = 1'b1;
    tick();
    vectors++; if (size !== 3'd3) begin miscompares++; $display("FAIL fullpop_size_a: got %0d expected 3", size); end
    vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL fullpop_ready: got %0h expected 1", enq_ready); end
    vectors++; if (rsp_data !== 32'h11) begin miscompares++; $display("FAIL fullpop_head: got %0h expected 11", rsp_data); end
    tick();
    enq_valid = 1'b0;
    vectors++; if (size !== 3'd3) begin miscompares++; $display("FAIL fullpop_size_b: got %0d expected 3", size); end
    vectors++; if (alm_full !== 1'b1) begin miscompares++; $display("FAIL fullpop_alm: got %0h expected 1", alm_full); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (rsp_data !== 32'h12 + 32'(i)) begin miscompares++; $display("FAIL fullpop_order[%0d]: got %0h expected %0h", i, rsp_data, 32'h12 + 32'(i)); end
      tick();
    end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL fullpop_empty: got %0h expected 0", rsp_valid); end
    vectors++; if (alm_full !== 1'b0) begin miscompares++; $display("FAIL fullpop_alm_clear: got %0h expected 0", alm_full); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got = 0;
    int mcount = 0;
    int cyc = 0;
    logic do_push;
    logic do_pop;
    while (got < 10 && cyc < 80) begin
      drive_enq(sent < 10, 32'(sent), 2'(sent), 8'(8'h80 + sent));
      rsp_ready = (cyc % 2 == 0);
      #1;
      vectors++; if (enq_ready !== (mcount != 4)) begin miscompares++; $display("FAIL wrap_ready[c%0d]: got %0h expected %0h", cyc, enq_ready, (mcount != 4)); end
      vectors++; if (size !== 3'(mcount)) begin miscompares++; $display("FAIL wrap_size[c%0d]: got %0d expected %0d", cyc, size, mcount); end
      vectors++; if (rsp_valid !== (mcount != 0)) begin miscompares++; $display("FAIL wrap_valid[c%0d]: got %0h expected %0h", cyc, rsp_valid, (mcount != 0)); end
      do_push = enq_valid && (mcount != 4);
      do_pop  = rsp_ready && (mcount != 0);
      if (do_pop) begin
        vectors++; if (rsp_tag !== 8'(8'h80 + got)) begin miscompares++; $display("FAIL wrap_tag[%0d]: got %0h expected %0h", got, rsp_tag, 8'(8'h80 + got)); end
        got++;
      end
      tick();
      mcount = mcount + int'(do_push) - int'(do_pop);
      sent   = sent + int'(do_push);
      cyc++;
    end
    enq_valid = 1'b0; rsp_ready = 1'b0;
    vectors++; if (cyc >= 80) begin miscompares++; $display("FAIL wrap_timeout: got %0d entries expected 10", got); end
    vectors++; if (size !== 3'd0) begin miscompares++; $display("FAIL wrap_final_size: got %0d expected 0", size); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    drive_enq(1'b1, 32'h100, 2'd0, 8'hC0);
    tick();
    for (int k = 1; k < 7; k++) begin
      drive_enq(1'b1, 32'h100 + 32'(k), 2'(k), 8'(8'hC0 + k));
      #1;
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %0h expected 1", k, rsp_valid); end
      vectors++; if (size !== 3'd1) begin miscompares++; $display("FAIL b2b_size[%0d]: got %0d expected 1", k, size); end
      vectors++; if (rsp_tag !== 8'(8'hC0 + k - 1)) begin miscompares++; $display("FAIL b2b_tag[%0d]: got %0h expected %0h", k, rsp_tag, 8'(8'hC0 + k - 1)); end
      tick();
    end
    enq_valid = 1'b0;
    vectors++; if (rsp_tag !== 8'hC6) begin miscompares++; $display("FAIL b2b_last_tag: got %0h expected c6", rsp_tag); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %0h expected 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(1'b1, 32'hA0 + 32'(i), 2'(i), 8'(8'hA0 + i));
      tick();
    end
    enq_valid = 1'b0;
    vectors++; if (size !== 3'd3) begin miscompares++; $display("FAIL rmid_pre_size: got %0d expected 3", size); end
    reset = 1'b0;
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %0h expected 0", rsp_valid); end
    vectors++; if (size !== 3'd0) begin miscompares++; $display("FAIL rmid_size: got %0d expected 0", size); end
    vectors++; if (alm_full !== 1'b0) begin miscompares++; $display("FAIL rmid_alm: got %0h expected 0", alm_full); end
    vectors++; if (enq_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_ready_low: got %0h expected 0", enq_ready); end
    reset = 1'b1;
    #1;
    vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready_high: got %0h expected 1", enq_ready); end
    rsp_ready = 1'b1;
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_stale: got %0h expected 0", rsp_valid); end
    drive_enq(1'b1, 32'hB0, 2'd3, 8'hB0);
    tick();
    enq_valid = 1'b0;
    vectors++; if (rsp_tag !== 8'hB0) begin miscompares++; $display("FAIL rmid_new_tag: got %0h expected b0", rsp_tag); end
    vectors++; if (rsp_data !== 32'hB0) begin miscompares++; $display("FAIL rmid_new_data: got %0h expected b0", rsp_data); end
    tick();
    vectors++; if (size !== 3'd0) begin miscompares++; $display("FAIL rmid_final_size: got %0d expected 0", size); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
